nr_fp_divider_seq: RTL and testbench

- Sequential, parametrised IEEE-754 Newton-Raphson floating-point divider: quotient = numerator / divisor.
- Shares one fixed-point mantissa multiplier across all iterations.
- The iteration count and the exponent/mantissa widths are parameters.
- Adds a valid/ready handshake, special-value handling and exception flags for use as a pipelined arithmetic slave.

---
 rtl/nr_fp_divider_seq_if.sv | 27 ++
 rtl/nr_fp_divider_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_nr_fp_divider_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/nr_fp_divider_seq_if.sv
// rtl/nr_fp_divider_seq_if.sv - operand/result handshake bundle for the Newton-Raphson divider
interface nr_fp_divider_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] numerator;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [3:0]   flags;
  logic         busy;

  modport slave (
    input  in_valid, numerator, divisor, out_ready,
    output in_ready, out_valid, quotient, flags, busy
  );

  modport master (
    output in_valid, numerator, divisor, out_ready,
    input  in_ready, out_valid, quotient, flags, busy
  );
endinterface

// File: rtl/nr_fp_divider_seq.sv
// rtl/nr_fp_divider_seq.sv - sequential IEEE-754 divider, Newton-Raphson reciprocal on one shared multiplier
// flags = {invalid, div_by_zero, overflow, underflow}; subnormals in flush to zero, none come out.
module nr_fp_divider_seq #(
  parameter int EXP_W      = 8,
  parameter int MAN_W      = 23,
  parameter int ITERATIONS = 4,
  parameter int GUARD_W    = 6
) (
  input logic                clk,
  input logic                rst,
  nr_fp_divider_seq_if.slave div_if
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int FW = MAN_W + GUARD_W;
  localparam int XW = FW + 2;
  localparam int EW = EXP_W + 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_ITER_A = 3'd2;
  localparam logic [2:0] S_ITER_B = 3'd3;
  localparam logic [2:0] S_FINAL  = 3'd4;
  localparam logic [2:0] S_NORM   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [XW-1:0] C48 = XW'((64'd48 << FW) / 64'd17);
  localparam logic [XW-1:0] C32 = XW'((64'd32 << FW) / 64'd17);
  localparam logic [XW-1:0] TWO = XW'(64'd2 << FW);
  // The reciprocal converges from below, so a quarter-ulp nudge lets exact quotients truncate exactly.
  localparam logic [XW-1:0] RND = XW'(64'd1 << (GUARD_W - 2));
  localparam logic signed [EW-1:0] EBIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
  localparam logic [2:0] LAST_IT = 3'(ITERATIONS - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

  logic               n_sign, d_sign, res_sign;
  logic [EXP_W-1:0]   n_exp, d_exp;
  logic [MAN_W-1:0]   n_man, d_man;
  logic               n_zero, n_nan, n_inf, d_zero, d_nan, d_inf;

  assign n_sign   = div_if.numerator[W-1];
  assign n_exp    = div_if.numerator[W-2 -: EXP_W];
  assign n_man    = div_if.numerator[MAN_W-1:0];
  assign d_sign   = div_if.divisor[W-1];
  assign d_exp    = div_if.divisor[W-2 -: EXP_W];
  assign d_man    = div_if.divisor[MAN_W-1:0];
  assign res_sign = n_sign ^ d_sign;
  assign n_zero   = (n_exp == '0);
  assign n_nan    = (&n_exp) & (|n_man);
  assign n_inf    = (&n_exp) & ~(|n_man);
  assign d_zero   = (d_exp == '0);
  assign d_nan    = (&d_exp) & (|d_man);
  assign d_inf    = (&d_exp) & ~(|d_man);

  logic [2:0]           state_q, state_d, iter_q, iter_d;
  logic                 sign_q, sign_d, spec_q, spec_d;
  logic signed [EW-1:0] exp_q, exp_d;
  logic [XW-1:0]        dm_q, dm_d, nm_q, nm_d, x_q, x_d, t_q, t_d, acc_q, acc_d;
  logic [W-1:0]         quotient_q, quotient_d;
  logic [3:0]           flags_q, flags_d;

  logic [XW-1:0]   mul_a, mul_b, prod_fx;
  logic [2*XW-1:0] prod_full;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      S_SETUP:  begin mul_a = C32;  mul_b = dm_q; end
      S_ITER_A: begin mul_a = dm_q; mul_b = x_q;  end
      S_ITER_B: begin mul_a = x_q;  mul_b = t_q;  end
      S_FINAL:  begin mul_a = nm_q; mul_b = x_q;  end
      default:  ;
    endcase
  end

  assign prod_full = {{XW{1'b0}}, mul_a} * {{XW{1'b0}}, mul_b};
  assign prod_fx   = XW'(prod_full >> FW);

  logic         spec_hit;
  logic [W-1:0] spec_word;
  logic [3:0]   spec_flags;

  always_comb begin
    spec_hit   = 1'b1;
    spec_word  = '0;
    spec_flags = 4'b0000;
    if (n_nan | d_nan) begin
      spec_word = QNAN;
    end else if ((n_zero & d_zero) | (n_inf & d_inf)) begin
      spec_word  = QNAN;
      spec_flags = 4'b1000;
    end else if (n_inf) begin
      spec_word = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (d_zero) begin
      spec_word  = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_flags = 4'b0100;
    end else if (d_inf | n_zero) begin
      spec_word = {res_sign, {(W - 1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // acc_q = 2*mN/mD lies in (1,4); bit XW-1 says whether it needs the 1-bit right shift.
  logic [XW-1:0]        acc_rnd;
  logic                 norm_hi;
  logic signed [EW-1:0] exp_n;
  logic [MAN_W-1:0]     man_n;
  logic [W-1:0]         norm_word;
  logic [3:0]           norm_flags;

  always_comb begin
    acc_rnd    = acc_q + RND;
    norm_hi    = acc_rnd[XW-1];
    exp_n      = norm_hi ? exp_q : exp_q - EW'(1);
    man_n      = norm_hi ? MAN_W'(acc_rnd >> (FW + 1 - MAN_W)) : MAN_W'(acc_rnd >> (FW - MAN_W));
    norm_word  = {sign_q, exp_n[EXP_W-1:0], man_n};
    norm_flags = 4'b0000;
    if (exp_n >= EMAX) begin
      norm_word  = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      norm_flags = 4'b0010;
    end else if (exp_n[EW-1] || exp_n == '0) begin
      norm_word  = {sign_q, {(W - 1){1'b0}}};
      norm_flags = 4'b0001;
    end
  end

  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    sign_d     = sign_q;
    spec_d     = spec_q;
    exp_d      = exp_q;
    dm_d       = dm_q;
    nm_d       = nm_q;
    x_d        = x_q;
    t_d        = t_q;
    acc_d      = acc_q;
    quotient_d = quotient_q;
    flags_d    = flags_q;
    case (state_q)
      S_IDLE: begin
        if (div_if.in_valid) begin
          sign_d = res_sign;
          exp_d  = $signed({2'b00, n_exp}) - $signed({2'b00, d_exp}) + EBIAS;
          dm_d   = {2'b00, 1'b1, d_man, {(GUARD_W - 1){1'b0}}};
          nm_d   = {1'b0, 1'b1, n_man, {GUARD_W{1'b0}}};
          iter_d = '0;
          spec_d = spec_hit;
          if (spec_hit) begin
            quotient_d = spec_word;
            flags_d    = spec_flags;
            state_d    = S_NORM;
          end else begin
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        x_d     = C48 - prod_fx;
        state_d = S_ITER_A;
      end
      S_ITER_A: begin
        t_d     = TWO - prod_fx;
        state_d = S_ITER_B;
      end
      S_ITER_B: begin
        x_d = prod_fx;
        if (iter_q == LAST_IT) begin
          state_d = S_FINAL;
        end else begin
          iter_d  = iter_q + 3'd1;
          state_d = S_ITER_A;
        end
      end
      S_FINAL: begin
        acc_d   = prod_fx;
        state_d = S_NORM;
      end
      S_NORM: begin
        if (!spec_q) begin
          quotient_d = norm_word;
          flags_d    = norm_flags;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (div_if.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      iter_q     <= '0;
      sign_q     <= 1'b0;
      spec_q     <= 1'b0;
      exp_q      <= '0;
      dm_q       <= '0;
      nm_q       <= '0;
      x_q        <= '0;
      t_q        <= '0;
      acc_q      <= '0;
      quotient_q <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      sign_q     <= sign_d;
      spec_q     <= spec_d;
      exp_q      <= exp_d;
      dm_q       <= dm_d;
      nm_q       <= nm_d;
      x_q        <= x_d;
      t_q        <= t_d;
      acc_q      <= acc_d;
      quotient_q <= quotient_d;
      flags_q    <= flags_d;
    end
  end

  assign div_if.in_ready  = (state_q == S_IDLE);
  assign div_if.out_valid = (state_q == S_DONE);
  assign div_if.busy      = (state_q != S_IDLE);
  assign div_if.quotient  = quotient_q;
  assign div_if.flags     = flags_q;
endmodule

// File: tb/tb_nr_fp_divider_seq.sv
// tb/tb_nr_fp_divider_seq.sv - directed checks of the Newton-Raphson divider
module tb_nr_fp_divider_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nr_fp_divider_seq_if bus ();

  nr_fp_divider_seq dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      step();
      lat++;
    end
    chk({tag, "_done"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] n, input logic [31:0] d,
                        output logic [31:0] q, output logic [3:0] f, output int lat);
    int w;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      step();
      w++;
    end
    bus.numerator = n;
    bus.divisor   = d;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    wait_valid(tag, lat);
    q = bus.quotient;
    f = bus.flags;
    if (bus.out_ready) step();
  endtask

  logic [31:0] q, diff;
  logic [3:0]  f;
  int          lat;

  initial begin
    bus.in_valid  = 1'b0;
    bus.numerator = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_quotient",  bus.quotient,       32'h0);
    chk("rst_flags",     32'(bus.flags),     32'h0);
    rst = 1'b0;
    step();

    run_op("six_three", 32'h40C00000, 32'h40400000, q, f, lat);
    chk("six_three_q",   q,         32'h40000000);
    chk("six_three_f",   32'(f),    32'h0);
    chk("six_three_lat", 32'(lat),  32'd11);

    run_op("third", 32'h3F800000, 32'h40400000, q, f, lat);
    diff = (q > 32'h3EAAAAAB) ? q - 32'h3EAAAAAB : 32'h3EAAAAAB - q;
    chk("third_ulp", 32'(diff <= 32'd2), 32'd1);
    chk("third_f",   32'(f), 32'h0);

    run_op("neg", 32'hC0F00000, 32'h40200000, q, f, lat);
    chk("neg_q", q, 32'hC0400000);
    chk("neg_f", 32'(f), 32'h0);

    run_op("divzero", 32'h40A00000, 32'h00000000, q, f, lat);
    chk("divzero_q",   q,        32'h7F800000);
    chk("divzero_f",   32'(f),   32'h4);
    chk("divzero_lat", 32'(lat), 32'd1);

    run_op("zz", 32'h00000000, 32'h00000000, q, f, lat);
    chk("zz_q",   q,        32'h7FC00000);
    chk("zz_f",   32'(f),   32'h8);
    chk("zz_lat", 32'(lat), 32'd1);

    run_op("xinf", 32'h3F800000, 32'h7F800000, q, f, lat);
    chk("xinf_q",   q,        32'h00000000);
    chk("xinf_f",   32'(f),   32'h0);
    chk("xinf_lat", 32'(lat), 32'd1);

    run_op("ovf", 32'h7F000000, 32'h3E800000, q, f, lat);
    chk("ovf_q", q, 32'h7F800000);
    chk("ovf_f", 32'(f), 32'h2);

    run_op("unf", 32'h00800000, 32'h7F000000, q, f, lat);
    chk("unf_q", q, 32'h00000000);
    chk("unf_f", 32'(f), 32'h1);

    // backpressure with in_valid held high while a result waits
    bus.out_ready = 1'b0;
    bus.numerator = 32'h40C00000;
    bus.divisor   = 32'h40400000;
    bus.in_valid  = 1'b1;
    step();
    bus.numerator = 32'hC0F00000;
    bus.divisor   = 32'h40200000;
    wait_valid("bp", lat);
    chk("bp_q0", bus.quotient, 32'h40000000);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_q_%0d", i),     bus.quotient,          32'h40000000);
      chk($sformatf("bp_f_%0d", i),     32'(bus.flags),        32'h0);
      chk($sformatf("bp_rdy_%0d", i),   32'(bus.in_ready),     32'd0);
      chk($sformatf("bp_valid_%0d", i), 32'(bus.out_valid),    32'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rdy_same_cycle", 32'(bus.in_ready), 32'd0);
    step();
    chk("bp_rdy_next", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_second_busy", 32'(bus.busy), 32'd1);
    wait_valid("bp2", lat);
    chk("bp_second_q", bus.quotient, 32'hC0400000);
    step();

    // reset while in ITER_B of the second iteration
    bus.numerator = 32'h3F800000;
    bus.divisor   = 32'h40400000;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
    chk("abort_busy",      32'(bus.busy),      32'd0);
    step();
    rst = 1'b0;
    step();
    run_op("after_abort", 32'h40C00000, 32'h40400000, q, f, lat);
    chk("after_abort_q",   q,        32'h40000000);
    chk("after_abort_lat", 32'(lat), 32'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
